// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, lane masks, lane helpers.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // LSB-justified lane masks for byte, halfword and word accesses
  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  // An access is misaligned when shifting its mask onto the addressed lane pushes bits past lane 3
  function automatic logic lane_misaligned(input logic [3:0] mask, input logic [1:0] off);
    logic [7:0] eff;
    eff = {4'b0000, mask} << off;
    return |eff[7:4];
  endfunction

  // Expand a 4-bit lane mask into a 32-bit byte bitmask
  function automatic logic [31:0] lane_expand(input logic [3:0] mask);
    logic [31:0] bm;
    bm = '0;
    for (int i = 0; i < 4; i++) begin
      bm[8*i +: 8] = {8{mask[i]}};
    end
    return bm;
  endfunction

endpackage

// File: rtl/dmem_responder_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after re_i; holds until the next read.
// Backpressure: none; accepts a read and/or write every cycle, write-first on the same word.
module dmem_responder_lane_ram
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Byte-lane writes: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Registered read; a lane written in the same cycle returns the new byte
  always_ff @(posedge clk) begin
    if (re_i) begin
      for (int i = 0; i < 4; i++) begin
        rdata_q[8*i +: 8] <= we_i[i] ? wdata_i[8*i +: 8] : mem_q[addr_i][8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM behind the core load/store port, with lane alignment and load right-justify.
// Latency: stores commit at end of request cycle; loads pulse mem_valid LATENCY cycles after request (+0..3 with DMEM_RANDOM_WAIT_EN).
// Backpressure: mem_ready drops from a load's request cycle through its response; requests after a low mem_ready are dropped and set err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic        err
);

  localparam int         LAT_EFF   = (LATENCY < 1) ? 1 : LATENCY;
  localparam logic [4:0] BASE_WAIT = 5'(LAT_EFF - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  off_q;
  logic [3:0]  mask_q;
  logic        mis_q;
  logic [31:0] rdata_q;
  logic        err_q, err_d;
  logic        ready_prev_q;

  logic [1:0]  off;
  logic        is_write, is_read, req;
  logic        wr_acc, rd_acc, req_drop;
  logic        wr_mis, rd_mis;
  logic [3:0]  eff_we;
  logic [31:0] eff_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] resp_data;
  logic [4:0]  extra_wait;
  logic [4:0]  wait_total;

  // Upper address bits beyond the RAM are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

  // Request decode: a store mask wins over a load mask
  assign off      = mem_addr[1:0];
  assign is_write = |mem_we;
  assign is_read  = (|mem_oe) && !is_write;
  assign req      = is_write || is_read;

  // Only requests following a cycle with mem_ready high are taken
  assign wr_acc   = is_write && ready_prev_q && (state_q == ST_IDLE);
  assign rd_acc   = is_read  && ready_prev_q && (state_q == ST_IDLE);
  assign req_drop = req && !(ready_prev_q && (state_q == ST_IDLE));

  assign wr_mis = lane_misaligned(mem_we, off);
  assign rd_mis = lane_misaligned(mem_oe, off);

  // Misaligned stores never reach the RAM
  assign eff_we    = (wr_acc && !wr_mis) ? (mem_we << off) : 4'b0000;
  assign eff_wdata = mem_wdata << {off, 3'b000};

  dmem_responder_lane_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .addr_i  (mem_addr[2 +: ADDR_WIDTH]),
    .we_i    (eff_we),
    .wdata_i (eff_wdata),
    .re_i    (rd_acc),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_RANDOM_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Free-running stall generator, sampled when a load is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign extra_wait = {3'b000, lfsr_q[1:0]};
`else
  assign extra_wait = 5'd0;
`endif

  // Cycles spent in WAIT plus the final RESP cycle equal the total load latency
  assign wait_total = BASE_WAIT + extra_wait;

  // Next-state logic for the load response sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_acc) begin
          if (wait_total == 5'd0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_total - 5'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 5'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 5'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and counter registers; reset drops any load in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Remember how to format the load data once the RAM word arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= 2'b00;
      mask_q <= 4'b0000;
      mis_q  <= 1'b0;
    end else if (rd_acc) begin
      off_q  <= off;
      mask_q <= mem_oe;
      mis_q  <= rd_mis;
    end
  end

  // Right-justify the addressed lanes and clear the rest; misaligned loads return zero
  assign resp_data = mis_q ? 32'h0 : ((ram_rdata >> {off_q, 3'b000}) & lane_expand(mask_q));

  // Hold the last response so mem_rdata stays stable until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    rdata_q <= 32'h0;
    else if (state_q == ST_RESP) rdata_q <= resp_data;
  end

  assign err_d = err_q | req_drop | (wr_acc && wr_mis) | (rd_acc && rd_mis);

  // Sticky error flag and last-cycle ready used to qualify the next request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q        <= 1'b0;
      ready_prev_q <= 1'b1;
    end else begin
      err_q        <= err_d;
      ready_prev_q <= mem_ready;
    end
  end

  assign mem_ready = (state_q == ST_IDLE) && !rd_acc;
  assign mem_valid = (state_q == ST_RESP);
  assign mem_rdata = (state_q == ST_RESP) ? resp_data : rdata_q;
  assign err       = err_q;

endmodule
